// File: rtl/plights_pkg.sv
// Shared constants for the plights demo: LED port address map, pattern width, FSM states.
package plights_pkg;

    localparam logic [31:0] LED_BASE_ADDR = 32'h9100_0000;
    localparam logic [31:0] LED_HI_OFS    = 32'd0;
    localparam logic [31:0] LED_LO_OFS    = 32'd1;
    localparam int          LED_WIDTH     = 16;
    localparam int          DWELL_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_RESP  = 2'd2
    } led_state_e;

endpackage

// File: rtl/plights_led_port_dwell_timer.sv
// Loadable down-counter; busy while the count is non-zero, saturates at zero.
module dwell_timer
    import plights_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               busy
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/plights_led_port.sv
// Wishbone classic slave for the 16-bit LED pattern: high byte is staged, low-byte write
// commits both atomically, then the port reports busy on wb_rty_o for a dwell period.
module plights_led_port
    import plights_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = LED_BASE_ADDR,
    parameter logic [31:0] DWELL_CYCLES = 32'd25_000_000
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic [LED_WIDTH-1:0] leds_o,
    output logic                 commit_o
);

    led_state_e               state_q, state_d;
    logic [LED_WIDTH/2-1:0]   shadow_hi;
    logic [31:0]              ofs;
    logic                     req, hit_hi, hit_lo, busy;
    logic                     ack_d, err_d, commit_d, shadow_we, rd_d;
    logic                     unused_bits;

    assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_dat_i[15:0], wb_sel_i[1:0]};

    assign ofs    = wb_adr_i - BASE_ADDR;
    assign hit_hi = (ofs == LED_HI_OFS);
    assign hit_lo = (ofs == LED_LO_OFS);
    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        commit_d  = 1'b0;
        shadow_we = 1'b0;
        rd_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!(hit_hi || hit_lo)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!wb_we_i) begin
                        ack_d   = 1'b1;
                        rd_d    = 1'b1;
                        state_d = ST_RESP;
                    end else if (hit_hi) begin
                        ack_d     = 1'b1;
                        shadow_we = wb_sel_i[3];
                        state_d   = ST_RESP;
                    end else if (busy) begin
                        state_d = ST_STALL;
                    end else begin
                        ack_d    = 1'b1;
                        commit_d = wb_sel_i[2];
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_STALL: begin
                // Master may abandon the stalled write; nothing is committed then.
                if (!(wb_cyc_i && wb_stb_i)) begin
                    state_d = ST_IDLE;
                end else if (!busy) begin
                    ack_d    = 1'b1;
                    commit_d = wb_sel_i[2];
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            commit_o  <= 1'b0;
            wb_dat_o  <= '0;
            shadow_hi <= '0;
            leds_o    <= '0;
        end else begin
            state_q  <= state_d;
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
            commit_o <= commit_d;
            wb_dat_o <= rd_d ? {leds_o, {(32-LED_WIDTH){1'b0}}} : '0;
            if (shadow_we) shadow_hi <= wb_dat_i[31:24];
            if (commit_d)  leds_o    <= {shadow_hi, wb_dat_i[23:16]};
        end
    end

    dwell_timer u_dwell (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .load     (commit_d),
        .load_val (DWELL_CYCLES),
        .busy     (busy)
    );

    assign wb_rty_o = busy;

endmodule
